// File: rtl/blast_stun_controller.sv
// -----------------------------------------------------------------------------
// blast_stun_controller
//
// Per-player stun manager for the grid arena. On an explode pulse, every player
// inside a square blast of half-width RADIUS around the bomb cell is hit. Each
// hit player then runs its own STUNNED -> IMMUNE -> READY sequence. stun_mask
// is used to gate movement and immune_mask to tint the sprite.
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high; aborts all stun/immune phases
//   explode      in   1-cycle pulse, the bomb detonates this cycle
//   bomb_x/y     in   bomb cell coordinates, sampled when explode=1
//   bomb_owner   in   index of the player that planted the bomb
//   pos_x/y      in   packed player coordinates, player i = [i*COORD_W +: COORD_W]
//   stun_mask    out  bit i high while player i is STUNNED
//   immune_mask  out  bit i high while player i is IMMUNE
//   stun_hit     out  1-cycle pulse when player i enters or reloads STUNNED
// -----------------------------------------------------------------------------
module blast_stun_controller #(
  parameter int NUM_PLAYERS   = 2,
  parameter int COORD_W       = 6,
  parameter int RADIUS        = 1,
  parameter int STUN_CYCLES   = 250000000,
  parameter int IMMUNE_CYCLES = 50000000,
  parameter int SELF_STUN     = 1,
  parameter int EXTEND        = 0,
  localparam int OWN_W        = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           explode,
  input  logic [COORD_W-1:0]             bomb_x,
  input  logic [COORD_W-1:0]             bomb_y,
  input  logic [OWN_W-1:0]               bomb_owner,
  input  logic [NUM_PLAYERS*COORD_W-1:0] pos_x,
  input  logic [NUM_PLAYERS*COORD_W-1:0] pos_y,
  output logic [NUM_PLAYERS-1:0]         stun_mask,
  output logic [NUM_PLAYERS-1:0]         immune_mask,
  output logic [NUM_PLAYERS-1:0]         stun_hit
);

  localparam int MAX_CYC = (STUN_CYCLES > IMMUNE_CYCLES) ? STUN_CYCLES : IMMUNE_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] STUN_LOAD = TW'(STUN_CYCLES - 1);
  localparam logic [TW-1:0] IMM_LOAD  = TW'((IMMUNE_CYCLES > 0) ? IMMUNE_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_READY   = 2'd0,
    ST_STUNNED = 2'd1,
    ST_IMMUNE  = 2'd2
  } state_e;

  state_e                  state_q   [NUM_PLAYERS];
  state_e                  state_d   [NUM_PLAYERS];
  logic   [TW-1:0]         timer_q   [NUM_PLAYERS];
  logic   [TW-1:0]         timer_d   [NUM_PLAYERS];
  logic   [NUM_PLAYERS-1:0] stun_hit_q;
  logic   [NUM_PLAYERS-1:0] stun_hit_d;

  logic signed [COORD_W:0] dx_s   [NUM_PLAYERS];
  logic signed [COORD_W:0] dy_s   [NUM_PLAYERS];
  logic        [COORD_W:0] dx_abs [NUM_PLAYERS];
  logic        [COORD_W:0] dy_abs [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0]  hit;

  // Hit test: differences are taken one bit wider than the coordinates, so a
  // bomb at one grid edge never reaches a player at the opposite edge.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      dx_s[i]   = $signed({1'b0, pos_x[i*COORD_W +: COORD_W]}) - $signed({1'b0, bomb_x});
      dy_s[i]   = $signed({1'b0, pos_y[i*COORD_W +: COORD_W]}) - $signed({1'b0, bomb_y});
      dx_abs[i] = dx_s[i][COORD_W] ? $unsigned(-dx_s[i]) : $unsigned(dx_s[i]);
      dy_abs[i] = dy_s[i][COORD_W] ? $unsigned(-dy_s[i]) : $unsigned(dy_s[i]);
      // An out-of-range owner index matches nobody, so nobody is exempt.
      hit[i] = explode
             && (int'(dx_abs[i]) <= RADIUS)
             && (int'(dy_abs[i]) <= RADIUS)
             && ((SELF_STUN != 0) || (int'(bomb_owner) != i));
    end
  end

  // Per-channel next state. The timer holds "cycles remaining minus one" so
  // the phase lasts exactly its configured length and stops at zero.
  always_comb begin
    stun_hit_d = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      case (state_q[i])
        ST_READY: begin
          if (hit[i]) begin
            state_d[i]    = ST_STUNNED;
            timer_d[i]    = STUN_LOAD;
            stun_hit_d[i] = 1'b1;
          end
        end
        ST_STUNNED: begin
          if (hit[i] && (EXTEND != 0)) begin
            timer_d[i]    = STUN_LOAD;
            stun_hit_d[i] = 1'b1;
          end else if (timer_q[i] == '0) begin
            if (IMMUNE_CYCLES > 0) begin
              state_d[i] = ST_IMMUNE;
              timer_d[i] = IMM_LOAD;
            end else begin
              state_d[i] = ST_READY;
            end
          end else begin
            timer_d[i] = timer_q[i] - TW'(1);
          end
        end
        ST_IMMUNE: begin
          if (timer_q[i] == '0) begin
            state_d[i] = ST_READY;
          end else begin
            timer_d[i] = timer_q[i] - TW'(1);
          end
        end
        default: begin
          state_d[i] = ST_READY;
          timer_d[i] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        state_q[i] <= ST_READY;
        timer_q[i] <= '0;
      end
      stun_hit_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
      stun_hit_q <= stun_hit_d;
    end
  end

  // Masks decode straight from the state register, so outputs stay registered.
  always_comb begin
    stun_mask   = '0;
    immune_mask = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      stun_mask[i]   = (state_q[i] == ST_STUNNED);
      immune_mask[i] = (state_q[i] == ST_IMMUNE);
    end
  end

  assign stun_hit = stun_hit_q;

endmodule
